// File: rtl/lab62_keyevent_pkg.sv
// Shared constants for the keyevent input port: register addresses,
// STATUS/IRQMASK/LIVE bit positions and the timestamp width.
package lab62_keyevent_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_LIVE    = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    localparam int MASK_NONEMPTY = 0;
    localparam int MASK_OVERFLOW = 1;
    localparam int LIVE_FLUSH    = 0;

    localparam int TS_W         = 16;
    localparam int DATA_FIELD_W = 16;

endpackage

// File: rtl/lab62_keyevent_fifo.sv
// Synchronous FIFO with push, pop and flush; head reads zero when empty.
// Pop on empty is ignored, push on full is accepted only alongside a pop.
module lab62_keyevent_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lab62_soc_keyevent_in.sv
// Avalon-MM input port: synchronizes in_port, queues every value change in a
// FIFO for the CPU and raises a maskable level irq. Define KEYEVENT_TIMESTAMP_EN
// to store a 16-bit cycle timestamp with each entry (DATA[31:16]).
module lab62_soc_keyevent_in
    import lab62_keyevent_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef KEYEVENT_TIMESTAMP_EN
    localparam int FIFO_W = DATA_W + TS_W;
`else
    localparam int FIFO_W = DATA_W;
`endif

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sync_val;
    logic [DATA_W-1:0] prev;
    logic              change;

    logic              rd;
    logic              wr;
    logic              pop;
    logic              flush;
    logic              ovf_clear;
    logic              mask_we;
    logic              drop;

    logic              overflow;
    logic [1:0]        mask;

    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [DATA_FIELD_W-1:0] data_field;
    logic                    unused_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // prev clears with reset so a nonzero input at release counts as an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= sync_val;
        end
    end

    assign change    = (sync_val != prev);
    assign rd        = chipselect & ~read_n;
    assign wr        = chipselect & ~write_n;
    assign pop       = rd & (address == ADDR_DATA);
    assign flush     = wr & (address == ADDR_LIVE) & writedata[LIVE_FLUSH];
    assign ovf_clear = wr & (address == ADDR_STATUS) & writedata[STAT_OVERFLOW];
    assign mask_we   = wr & (address == ADDR_IRQMASK);
    assign drop      = change & fifo_full & ~pop & ~flush;

    assign unused_bits = ^writedata[31:3];

    // A fresh drop outranks a same-cycle clear so the event is never hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= writedata[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (mask[MASK_NONEMPTY] & ~fifo_empty) |
                   (mask[MASK_OVERFLOW] & overflow);
        end
    end

`ifdef KEYEVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_count <= '0;
        end else begin
            ts_count <= ts_count + TS_W'(1);
        end
    end

    assign fifo_din = {ts_count, sync_val};
`else
    assign fifo_din = sync_val;
`endif

    lab62_keyevent_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (change),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        data_field               = '0;
        data_field[DATA_W-1:0]   = fifo_head[DATA_W-1:0];
    end

    // Zero-wait-state read mux; address alone selects, chipselect only gates side effects.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
`ifdef KEYEVENT_TIMESTAMP_EN
                readdata = {fifo_head[FIFO_W-1 -: TS_W], data_field};
`else
                readdata = {16'b0, data_field};
`endif
            end
            ADDR_STATUS: begin
                readdata[STAT_EMPTY]                = fifo_empty;
                readdata[STAT_FULL]                 = fifo_full;
                readdata[STAT_OVERFLOW]             = overflow;
                readdata[STAT_COUNT_LSB +: CNT_W]   = fifo_count;
            end
            ADDR_IRQMASK: begin
                readdata[1:0] = mask;
            end
            default: begin
                readdata[DATA_W-1:0] = sync_val;
            end
        endcase
    end

endmodule

// File: tb/tb_lab62_soc_keyevent_in.sv
// Self-checking bench for lab62_soc_keyevent_in: a queue model of the FIFO
// holds expected values pushed as in_port changes and popped on DATA reads.
module tb_lab62_soc_keyevent_in;
    import lab62_keyevent_pkg::*;

    localparam int MODEL_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int          exp_q[$];
    bit          model_ovf;
    int          check_count;
    int          pass_count;

    lab62_soc_keyevent_in #(
        .DATA_W      (8),
        .DEPTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] val);
        if (exp_q.size() < MODEL_DEPTH) begin
            exp_q.push_back(int'(val));
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s                 = '0;
        s[STAT_EMPTY]     = (exp_q.size() == 0);
        s[STAT_FULL]      = (exp_q.size() == MODEL_DEPTH);
        s[STAT_OVERFLOW]  = model_ovf;
        s[15:8]           = 8'(exp_q.size());
        return s;
    endfunction

    task automatic applyStimulus(input logic [7:0] val);
        in_port = val;
        model_push(val);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = model_status();
        bus_read(ADDR_STATUS, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic read_data(output logic [31:0] d);
        logic [31:0] exp;
        bus_read(ADDR_DATA, d);
        if (exp_q.size() > 0) begin
            exp = 32'(exp_q.pop_front());
        end else begin
            exp = '0;
        end
        checkOutput("data_lo", {16'b0, d[15:0]}, exp);
`ifndef KEYEVENT_TIMESTAMP_EN
        checkOutput("data_hi", {16'b0, d[31:16]}, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [15:0] delta;

        check_count = 0;
        pass_count  = 0;
        model_ovf   = 1'b0;
        reset       = 1'b1;
        address     = ADDR_DATA;
        chipselect  = 1'b0;
        read_n      = 1'b1;
        write_n     = 1'b1;
        writedata   = '0;
        in_port     = 8'h00;
        d           = '0;
        d1          = '0;
        d2          = '0;
        delta       = '0;

        tick(3);
        checkOutput("irq_in_reset", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick(4);

        // Idle after reset
        read_status("status_idle");
        checkOutput("irq_idle", {31'b0, irq}, 32'h0);
        read_data(d);
        bus_read(ADDR_IRQMASK, d);
        checkOutput("mask_reset", d, 32'h0);

        // Single event with non-empty interrupt
        bus_write(ADDR_IRQMASK, 32'h1);
        applyStimulus(8'h1A);
        tick(3);
        checkOutput("irq_before", {31'b0, irq}, 32'h0);
        read_status("status_one");
        checkOutput("irq_rise", {31'b0, irq}, 32'h1);
        read_data(d);
        checkOutput("irq_hold", {31'b0, irq}, 32'h1);
        read_status("status_drained");
        checkOutput("irq_fall", {31'b0, irq}, 32'h0);

        // Overflow with overflow interrupt
        bus_write(ADDR_IRQMASK, 32'h2);
        bus_read(ADDR_IRQMASK, d);
        checkOutput("mask_rw", d, 32'h2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h21 + 8'(i));
            tick(2);
        end
        tick(2);
        read_status("status_overflow");
        checkOutput("irq_ovf", {31'b0, irq}, 32'h1);
        for (int i = 0; i < MODEL_DEPTH; i++) begin
            read_data(d);
        end
        read_status("status_ovf_empty");
        bus_write(ADDR_STATUS, 32'h4);
        model_ovf = 1'b0;
        checkOutput("irq_ovf_hold", {31'b0, irq}, 32'h1);
        tick(1);
        checkOutput("irq_ovf_fall", {31'b0, irq}, 32'h0);
        read_status("status_ovf_clear");

        // Full FIFO: pop and push land on the same edge
        for (int i = 0; i < MODEL_DEPTH; i++) begin
            applyStimulus(8'h31 + 8'(i));
            tick(2);
        end
        tick(2);
        read_status("status_full");
        in_port = 8'h39;
        tick(2);
        read_data(d);
        model_push(8'h39);
        read_status("status_full_pushpop");
        for (int i = 0; i < MODEL_DEPTH; i++) begin
            read_data(d);
        end
        read_status("status_after_drain");

        // Flush collides with a push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h41 + 8'(i));
            tick(2);
        end
        tick(2);
        read_status("status_three");
        in_port = 8'h44;
        tick(2);
        bus_write(ADDR_LIVE, 32'h1);
        exp_q.delete();
        read_status("status_flushed");
        tick(4);
        read_status("status_flush_settled");
        bus_read(ADDR_LIVE, d);
        checkOutput("live", d, 32'h44);
        bus_write(ADDR_DATA, 32'hFF);
        read_status("status_data_write");

        // Asynchronous reset mid-operation, nonzero input at release
        bus_write(ADDR_IRQMASK, 32'h1);
        applyStimulus(8'h61);
        tick(5);
        checkOutput("irq_pre_reset", {31'b0, irq}, 32'h1);
        in_port = 8'h62;
        address = ADDR_STATUS;
        #2 reset = 1'b1;
        #1;
        checkOutput("irq_async_reset", {31'b0, irq}, 32'h0);
        checkOutput("status_async_reset", readdata, 32'h1);
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_push(8'h62);
        tick(4);
        read_status("status_release_event");
        bus_read(ADDR_IRQMASK, d);
        checkOutput("mask_after_reset", d, 32'h0);
        read_data(d);

`ifdef KEYEVENT_TIMESTAMP_EN
        // Timestamps of two events 100 clocks apart
        applyStimulus(8'h71);
        tick(100);
        applyStimulus(8'h72);
        tick(4);
        read_data(d1);
        read_data(d2);
        delta = d2[31:16] - d1[31:16];
        checkOutput("ts_delta", {16'b0, delta}, 32'd100);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/lab62_soc_keyevent_in.md
Name: lab62_soc_keyevent_in

Overview:
- Avalon-MM slave input port; the CPU-read counterpart to the write-only keycode output PIOs.
- Synchronizes an external DATA_W-bit bus (keycode/button state from fabric logic) and detects every value change.
- Queues each new value in a small FIFO that the Nios II pops over the bus.
- Raises a level interrupt on non-empty and/or overflow, so software never misses a short-lived key event.

Parameters:
- DATA_W, 8, width of in_port; legal range 1..16.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- SYNC_STAGES, 2, synchronizer flops on in_port; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  Avalon chipselect.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, 0 wait states.
- in_port  in  DATA_W  asynchronous external input bus.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset: all flops clear. This includes the synchronizer, the prev register, FIFO pointers/count, overflow, mask and irq. irq=0 and readdata follows the cleared state.
- Sync and detect:
  - in_port passes through SYNC_STAGES flops to give sync_val.
  - prev <= sync_val every cycle.
  - Change = (sync_val != prev); it pushes sync_val the same cycle.
  - Latency from in_port change to FIFO visible is SYNC_STAGES+1 clocks.
  - A nonzero in_port at reset release produces one event.
- Read/write qualifiers: rd = chipselect & ~read_n; wr = chipselect & ~write_n.
- Register map, selected by address:
  - 0 DATA (RO): readdata = {16'b0, zero-extended FIFO head}. Reads 0 when empty. rd pops the head at the clock edge ending the access. Pop on empty has no effect.
  - 1 STATUS:
    - Read: [0] empty, [1] full, [2] overflow (sticky), [15:8] count, all other bits 0. Reads have no side effects.
    - wr with writedata[2]=1 clears overflow.
  - 2 IRQMASK (RW, reset 0): [0] irq on non-empty, [1] irq on overflow. Other bits read 0.
  - 3 LIVE:
    - Read: {zero, sync_val}.
    - wr with writedata[0]=1 flushes the FIFO; overflow is unaffected.
- FIFO boundaries:
  - Push when full: the value is dropped and overflow=1. prev still updates.
  - Push and pop in the same cycle when full: both happen and count is unchanged.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is accepted.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
  - Flush in the same cycle as a push: flush wins and the pushed value is discarded.
- irq <= (mask[0] & ~empty) | (mask[1] & overflow). This is one cycle after the condition, and it deasserts one cycle after the condition clears.
- Writes to address 0 are ignored.
- readdata is muxed from address regardless of chipselect.
- Reset asserted mid-operation returns every register to reset values immediately (async).

Optional Feature:
- Macro: KEYEVENT_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0) is captured alongside each pushed value.
  - DATA reads return {timestamp[15:0], 16-bit zero-extended value}.
  - FIFO width grows by 16.
- Undefined: no counter is built and DATA[31:16] reads 0.

Decomposition:
- Package lab62_keyevent_pkg holds:
  - Register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_IRQMASK=2, ADDR_LIVE=3.
  - STATUS bit-index constants.
  - Timestamp width constant (16).
- One sub-module, lab62_keyevent_fifo: a synchronous FIFO with push, pop, flush, head, count, full and empty, parameterized on width and depth.
- Synchronizer, detect logic and register file stay in the top.

Test Plan:
- Reset, then in_port=0x00 steady: STATUS reads 0x0000_0001, irq=0, DATA reads 0.
- Set IRQMASK=0x1. Drive in_port 0x00->0x1A: after 3 clocks STATUS count=1, irq=1 the next clock. DATA read returns 0x1A, then STATUS=empty and irq drops 1 cycle later.
- Drive 9 distinct values with DEPTH=8 and no reads: count=8, full=1, overflow=1. DATA pops return the first 8 values in order; the 9th is lost. Write STATUS 0x4 and overflow clears.
- With FIFO full, pop and new in_port change in the same cycle: count stays 8 and the newest value appears last.
- With FIFO holding 3 entries, write LIVE 0x1 in the same cycle as an in_port change: count=0 after the edge and no entry is added.
- With KEYEVENT_TIMESTAMP_EN: two changes 100 clocks apart give DATA[31:16] values that differ by 100.
